// File: rtl/dmem_responder.sv
// Data-memory responder: DEPTH little-endian 64-bit words behind a valid/ready
// request channel and a valid/ready response channel, with programmable wait states.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_count;
    logic        r_write;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [63:0] r_mem [DEPTH];

    logic [IDXW-1:0] w_idx;
    logic [2:0]      w_lane;
    logic [5:0]      w_shamt;
    logic            w_misaligned;
    logic            w_oor;
    logic            w_err;
    logic [63:0]     w_word;
    logic [63:0]     w_shifted;
    logic [63:0]     w_load;
    logic [63:0]     w_fmask;
    logic [63:0]     w_mask;
    logic [63:0]     w_wshift;
    logic            w_access;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        w_access   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_count == 4'd0) begin
                    w_access = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Address decode and error detection on the latched request
    assign w_idx   = r_addr[IDXW+2:3];
    assign w_lane  = r_addr[2:0];
    assign w_shamt = {w_lane, 3'b000};
    assign w_oor   = (r_addr[63:3] >= 61'(DEPTH));

    always_comb begin
        w_misaligned = 1'b0;
        case (r_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = r_addr[0];
            2'b10:   w_misaligned = (r_addr[1:0] != 2'b00);
            default: w_misaligned = (r_addr[2:0] != 3'b000);
        endcase
    end

    assign w_err     = w_misaligned | w_oor;
    assign w_word    = w_oor ? 64'd0 : r_mem[w_idx];
    assign w_shifted = w_word >> w_shamt;

    // Load extraction with sign or zero extension; doubles ignore r_unsigned
    always_comb begin
        w_load = 64'd0;
        case (r_size)
            2'b00: w_load = r_unsigned ? {56'd0, w_shifted[7:0]}
                                       : {{56{w_shifted[7]}}, w_shifted[7:0]};
            2'b01: w_load = r_unsigned ? {48'd0, w_shifted[15:0]}
                                       : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'b10: w_load = r_unsigned ? {32'd0, w_shifted[31:0]}
                                       : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_fmask = 64'd0;
        case (r_size)
            2'b00:   w_fmask = 64'h0000_0000_0000_00FF;
            2'b01:   w_fmask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_fmask = 64'h0000_0000_FFFF_FFFF;
            default: w_fmask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign w_mask   = w_fmask << w_shamt;
    assign w_wshift = (r_wdata & w_fmask) << w_shamt;

    // Request latch, wait counter, result registers and storage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= 4'd0;
            r_write    <= 1'b0;
            r_addr     <= 64'd0;
            r_wdata    <= 64'd0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_rdata    <= 64'd0;
            r_err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 64'd0;
            end
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_write    <= req_write;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_count    <= 4'(WAIT_CYCLES);
            end else if (r_state == S_WAIT && r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end

            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_write) ? 64'd0 : w_load;
                if (r_write && !w_err) begin
                    r_mem[w_idx] <= (w_word & ~w_mask) | (w_wshift & w_mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: loads/stores, extension,
// error flags, response back-pressure and reset during a pending access.
module tb_dmem_responder;

    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int checkCount;
    int errorCount;

    logic [63:0] gotData;
    logic        gotErr;
    int          gotLat;
    logic [63:0] heldData;
    logic        sawResp;

    dmem_responder #(
        .DEPTH(DEPTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one request, measures latency to resp_valid and optionally releases the response
    task automatic applyStimulus(input logic wr, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [1:0] size,
                                 input logic uns, input logic release_resp);
        int waitCnt;
        waitCnt = 0;
        gotLat  = -1;
        gotData = 64'hDEAD_DEAD_DEAD_DEAD;
        gotErr  = 1'bx;
        while (!req_ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!req_ready) begin
            checkOutput("req_ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 64'hFFFF_FFFF_FFFF_FFF8;
        req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                gotLat = c;
                break;
            end
        end
        if (gotLat < 0) begin
            checkOutput("resp_valid_timeout", 64'(resp_valid), 64'd1);
            return;
        end
        gotData = resp_rdata;
        gotErr  = resp_err;
        if (release_resp) begin
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
    endtask

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        resp_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_rdata", resp_rdata, 64'd0);
        checkOutput("rst_err", 64'(resp_err), 64'd0);

        // Double store then load, with latency measurement
        applyStimulus(1'b1, 64'h10, 64'h8877_6655_4433_2211, 2'b11, 1'b0, 1'b1);
        checkOutput("sd_err", 64'(gotErr), 64'd0);
        checkOutput("sd_rdata", gotData, 64'd0);
        checkOutput("sd_latency", 64'(gotLat), 64'(WAIT_CYCLES + 1));
        applyStimulus(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 1'b1);
        checkOutput("ld_rdata", gotData, 64'h8877_6655_4433_2211);
        checkOutput("ld_err", 64'(gotErr), 64'd0);
        checkOutput("ld_latency", 64'(gotLat), 64'(WAIT_CYCLES + 1));

        // Narrow loads with extension
        applyStimulus(1'b0, 64'h17, 64'd0, 2'b00, 1'b0, 1'b1);
        checkOutput("lb_17", gotData, 64'hFFFF_FFFF_FFFF_FF88);
        applyStimulus(1'b0, 64'h17, 64'd0, 2'b00, 1'b1, 1'b1);
        checkOutput("lbu_17", gotData, 64'h0000_0000_0000_0088);
        applyStimulus(1'b0, 64'h12, 64'd0, 2'b01, 1'b0, 1'b1);
        checkOutput("lh_12", gotData, 64'h0000_0000_0000_4433);
        applyStimulus(1'b0, 64'h14, 64'd0, 2'b10, 1'b0, 1'b1);
        checkOutput("lw_14", gotData, 64'hFFFF_FFFF_8877_6655);
        applyStimulus(1'b0, 64'h14, 64'd0, 2'b10, 1'b1, 1'b1);
        checkOutput("lwu_14", gotData, 64'h0000_0000_8877_6655);

        // Byte store only touches its lane
        applyStimulus(1'b1, 64'h11, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00, 1'b0, 1'b1);
        checkOutput("sb_err", 64'(gotErr), 64'd0);
        applyStimulus(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 1'b1);
        checkOutput("sb_readback", gotData, 64'h8877_6655_4433_AB11);

        // Misaligned and out-of-range errors
        applyStimulus(1'b1, 64'h12, 64'hCAFE_BABE, 2'b10, 1'b0, 1'b1);
        checkOutput("sw_mis_err", 64'(gotErr), 64'd1);
        checkOutput("sw_mis_rdata", gotData, 64'd0);
        applyStimulus(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 1'b1);
        checkOutput("sw_mis_nowrite", gotData, 64'h8877_6655_4433_AB11);
        applyStimulus(1'b0, 64'h11, 64'd0, 2'b01, 1'b0, 1'b1);
        checkOutput("lh_mis_err", 64'(gotErr), 64'd1);
        applyStimulus(1'b0, 64'(DEPTH * 8), 64'd0, 2'b11, 1'b0, 1'b1);
        checkOutput("ld_oor_err", 64'(gotErr), 64'd1);
        checkOutput("ld_oor_rdata", gotData, 64'd0);

        // Last valid word
        applyStimulus(1'b1, 64'(DEPTH * 8 - 8), 64'h0123_4567_89AB_CDEF, 2'b11, 1'b0, 1'b1);
        checkOutput("sd_last_err", 64'(gotErr), 64'd0);
        applyStimulus(1'b0, 64'(DEPTH * 8 - 1), 64'd0, 2'b00, 1'b1, 1'b1);
        checkOutput("lbu_last", gotData, 64'h0000_0000_0000_0001);

        // Back-pressure on the response channel
        applyStimulus(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 1'b0);
        heldData = gotData;
        checkOutput("bp_first", heldData, 64'h8877_6655_4433_AB11);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput("bp_valid", 64'(resp_valid), 64'd1);
            checkOutput("bp_rdata", resp_rdata, heldData);
            checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("bp_release_valid", 64'(resp_valid), 64'd0);
        checkOutput("bp_release_ready", 64'(req_ready), 64'd1);

        // Reset during WAIT drops the store and clears memory
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h08;
        req_wdata = 64'h1234;
        req_size  = 2'b11;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        sawResp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (resp_valid) sawResp = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("rst_wait_noresp", 64'(sawResp), 64'd0);
        applyStimulus(1'b0, 64'h08, 64'd0, 2'b11, 1'b0, 1'b1);
        checkOutput("rst_wait_nocommit", gotData, 64'd0);
        applyStimulus(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 1'b1);
        checkOutput("rst_mem_cleared", gotData, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
